// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences a multi-cycle MAC op from E through clear, element steps, drain and RF writeback
module mac_seq_ctrl #(
   parameter int LEN_W = 8,
   parameter int RD_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MacStartE,
   input  logic [LEN_W-1:0] MacLenE,
   input  logic [RD_W-1:0]  MacRdE,
   input  logic             MacAbort,
   input  logic             StepReady,
   input  logic             AccDone,
   input  logic             RegWriteW,
   output logic             StallFD,
   output logic             FlushE,
   output logic             AccClr,
   output logic             StepValid,
   output logic [LEN_W-1:0] StepIdx,
   output logic             WbEn,
   output logic [RD_W-1:0]  WbRd,
   output logic             MacBusy,
   output logic             MacDone
);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, WB} state_t;
   state_t           state, state_nx;
   logic [LEN_W-1:0] len_r, idx_r, len_m1;
   logic [RD_W-1:0]  rd_r;
   logic             capture, last;
   assign capture = (state == IDLE) && MacStartE && !MacAbort;
   assign len_m1  = len_r - 1'b1;
   assign last    = idx_r == len_m1;
   assign MacBusy = state != IDLE;
   assign MacDone = WbEn;
   // gated by rst so the combinational path from MacStartE is also quiet in reset
   assign StallFD = rst && (MacStartE || MacBusy);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         len_r <= '0;
         idx_r <= '0;
         rd_r  <= '0;
      end else begin
         state <= state_nx;
         if (capture) begin
            len_r <= MacLenE;
            rd_r  <= MacRdE;
            idx_r <= '0;
         end else if (state == RUN && StepReady && !last) begin
            idx_r <= idx_r + 1'b1;
         end
      end
   end
   always_comb begin
      state_nx  = state;
      FlushE    = 1'b0;
      AccClr    = 1'b0;
      StepValid = 1'b0;
      StepIdx   = '0;
      WbEn      = 1'b0;
      WbRd      = '0;
      case (state)
         IDLE: begin
            FlushE   = capture && rst;
            state_nx = capture ? CLEAR : IDLE;
         end
         CLEAR: begin
            AccClr   = 1'b1;
            state_nx = MacAbort ? IDLE : (len_r == '0) ? WB : RUN;
         end
         RUN: begin
            StepValid = 1'b1;
            StepIdx   = idx_r;
            state_nx  = MacAbort ? IDLE : (StepReady && last) ? DRAIN : RUN;
         end
         DRAIN: state_nx = MacAbort ? IDLE : AccDone ? WB : DRAIN;
         WB: begin
            WbRd     = rd_r;
            WbEn     = !RegWriteW;
            state_nx = RegWriteW ? WB : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule
